uart_rx_cmd_ctrl: RTL



---
 rtl/uart_mem_pkg.sv | 20 ++
 rtl/frame_assembler.sv | 56 +++++
 rtl/uart_rx_cmd_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_pkg.sv
// Shared definitions for the UART-to-memory command path.
//   ctrl_state_t      : command sequencer state encoding
//   WR_OPCODE_DEFAULT : opcode frame that starts a write command
//   frames_for()      : number of frames needed to fill a field
package uart_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        ISSUE = 2'd3
    } ctrl_state_t;

    localparam logic [7:0] WR_OPCODE_DEFAULT = 8'hA5;

    function automatic int frames_for(input int width, input int fw);
        return width / fw;
    endfunction

endpackage

// File: rtl/frame_assembler.sv
// Shift-in register that builds a wide field from consecutive frames,
// least significant frame first (frame k lands in bits [k*FW +: FW]).
// Ports:
//   clk, rst_l : clock, asynchronous active-low reset
//   clear_i    : restart at frame 0 (contents kept)
//   load_i     : write frame_i into the current slot and advance
//   frame_i    : incoming frame
//   data_o     : assembled field
//   last_o     : the next load fills the final slot
module frame_assembler
    import uart_mem_pkg::*;
#(
    parameter int FRAME_WIDTH = 8,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic [FRAME_WIDTH-1:0] frame_i,
    output logic [OUT_WIDTH-1:0]   data_o,
    output logic                   last_o
);

    localparam int FRAMES = frames_for(OUT_WIDTH, FRAME_WIDTH);
    localparam int CW     = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;

    assign last_o = (cnt_q == CW'(FRAMES - 1));
    assign data_o = data_q;

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            data_d[cnt_q*FRAME_WIDTH +: FRAME_WIDTH] = frame_i;
            // Wrap after the final slot so the next field starts at frame 0.
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver. Consumes frames
// (opcode, address frames, data frames) and issues one memory write
// per command over a req/ack handshake.
// Ports:
//   clk, rst_l           : clock, asynchronous active-low reset
//   rx_data, rx_done     : received frame and its ready flag
//   clr_rx_done          : one-cycle pulse consuming the frame
//   mem_req/mem_ack      : write request held until acknowledged
//   mem_addr, mem_wdata  : write address/data, stable while mem_req
//   busy                 : sequencer not in IDLE
//   cmd_count            : completed writes, wraps at 255
//   err_opcode/_timeout/_overrun : sticky error flags, cleared by clr_err
//   dbg_state            : current sequencer state
//
// Handshakes: a frame is consumed on a cycle where rx_done is high, no
// clear is already in flight and the sequencer is not in ISSUE; the
// clear pulse follows one cycle later. A write is offered by raising
// mem_req and completes on the first clk edge that samples mem_ack high
// while in ISSUE; mem_ack at any other time is ignored.
module uart_rx_cmd_ctrl
    import uart_mem_pkg::*;
#(
    parameter int                     FRAME_WIDTH    = 8,
    parameter int                     ADDR_WIDTH     = 16,
    parameter int                     DATA_WIDTH     = 32,
    parameter logic [FRAME_WIDTH-1:0] WR_OPCODE      = FRAME_WIDTH'(WR_OPCODE_DEFAULT),
    parameter int                     TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic [FRAME_WIDTH-1:0] rx_data,
    input  logic                   rx_done,
    output logic                   clr_rx_done,
    output logic                   mem_req,
    input  logic                   mem_ack,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   busy,
    output logic [7:0]             cmd_count,
    output logic                   err_opcode,
    output logic                   err_timeout,
    output logic                   err_overrun,
    input  logic                   clr_err,
    output ctrl_state_t            dbg_state
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    if ((ADDR_WIDTH % FRAME_WIDTH) != 0) begin : g_bad_addr_width
        $error("ADDR_WIDTH must be a multiple of FRAME_WIDTH");
    end
    if ((DATA_WIDTH % FRAME_WIDTH) != 0) begin : g_bad_data_width
        $error("DATA_WIDTH must be a multiple of FRAME_WIDTH");
    end
    if (TIMEOUT_CYCLES <= 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be greater than zero");
    end

    ctrl_state_t   state_q, state_d;
    logic          clr_q;
    logic          clr_prev_q;
    logic          rx_prev_q;
    logic          mem_req_q, mem_req_d;
    logic [7:0]    cmd_cnt_q, cmd_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_op_q, err_op_d;
    logic          err_tmo_q, err_tmo_d;
    logic          err_ovr_q, err_ovr_d;

    logic consume;
    logic asm_clear, addr_load, data_load;
    logic addr_last, data_last;
    logic op_event, tmo_event, ovr_event;

    // clr_q in the guard stops the same frame being taken twice while
    // the receiver has not yet dropped rx_done.
    assign consume = rx_done & ~clr_q & (state_q != ISSUE);

    // A frame vanished without our clear having preceded the drop.
    assign ovr_event = rx_prev_q & ~rx_done & ~clr_prev_q;

    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        cmd_cnt_d = cmd_cnt_q;
        tmo_d     = tmo_q;
        asm_clear = 1'b0;
        addr_load = 1'b0;
        data_load = 1'b0;
        op_event  = 1'b0;
        tmo_event = 1'b0;

        if (consume) begin
            tmo_d = TW'(TIMEOUT_CYCLES);
        end

        case (state_q)
            IDLE: begin
                if (consume) begin
                    if (rx_data == WR_OPCODE) begin
                        state_d   = ADDR;
                        asm_clear = 1'b1;
                    end else begin
                        op_event = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (consume) begin
                    addr_load = 1'b1;
                    if (addr_last) state_d = DATA;
                end else if (tmo_q == '0) begin
                    state_d   = IDLE;
                    tmo_event = 1'b1;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            DATA: begin
                if (consume) begin
                    data_load = 1'b1;
                    if (data_last) begin
                        state_d   = ISSUE;
                        mem_req_d = 1'b1;
                    end
                end else if (tmo_q == '0) begin
                    state_d   = IDLE;
                    tmo_event = 1'b1;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Sticky flags: a new event outranks a simultaneous clear.
    assign err_op_d  = (err_op_q  & ~clr_err) | op_event;
    assign err_tmo_d = (err_tmo_q & ~clr_err) | tmo_event;
    assign err_ovr_d = (err_ovr_q & ~clr_err) | ovr_event;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            clr_q      <= 1'b0;
            clr_prev_q <= 1'b0;
            rx_prev_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            cmd_cnt_q  <= '0;
            tmo_q      <= '0;
            err_op_q   <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= consume;
            clr_prev_q <= clr_q;
            rx_prev_q  <= rx_done;
            mem_req_q  <= mem_req_d;
            cmd_cnt_q  <= cmd_cnt_d;
            tmo_q      <= tmo_d;
            err_op_q   <= err_op_d;
            err_tmo_q  <= err_tmo_d;
            err_ovr_q  <= err_ovr_d;
        end
    end

    frame_assembler #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .OUT_WIDTH   (ADDR_WIDTH)
    ) u_addr_asm (
        .clk     (clk),
        .rst_l   (rst_l),
        .clear_i (asm_clear),
        .load_i  (addr_load),
        .frame_i (rx_data),
        .data_o  (mem_addr),
        .last_o  (addr_last)
    );

    frame_assembler #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .OUT_WIDTH   (DATA_WIDTH)
    ) u_data_asm (
        .clk     (clk),
        .rst_l   (rst_l),
        .clear_i (asm_clear),
        .load_i  (data_load),
        .frame_i (rx_data),
        .data_o  (mem_wdata),
        .last_o  (data_last)
    );

    assign clr_rx_done = clr_q;
    assign mem_req     = mem_req_q;
    assign busy        = (state_q != IDLE);
    assign cmd_count   = cmd_cnt_q;
    assign err_opcode  = err_op_q;
    assign err_timeout = err_tmo_q;
    assign err_overrun = err_ovr_q;
    assign dbg_state   = state_q;

endmodule
